shift_sequencer: RTL and testbench
==================================

Name: shift_sequencer

Overview:
- Command-driven controller that sequences a universal shift register (USR) with modes 00 hold, 01 shift right, 10 shift left and 11 parallel load.
- Accepts one command per valid/ready handshake. A command is an optional parallel load followed by N shifts in one direction.
- Drives the USR mode, serial-in and parallel-data pins cycle by cycle, then pulses done.
- Sits between a register-file/CPU-side requester and one USR instance.

Parameters:
- WIDTH, 4, USR data width.
- CNT_W, 3, width of the shift-count field; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock, the only clock
- rst  input  1  synchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  controller can accept a command
- cmd_load  input  1  parallel-load cmd_data before shifting
- cmd_op  input  2  01 shift right, 10 shift left, 00/11 no shift
- cmd_count  input  CNT_W  number of shift cycles
- cmd_sin  input  1  serial-in bit for every shift of this command
- cmd_data  input  WIDTH  parallel-load value
- usr_q  input  WIDTH  USR output; used only when ROTATE_EN is defined
- usr_sel  output  2  USR mode select
- usr_shift_r  output  1  USR right serial input
- usr_shift_l  output  1  USR left serial input
- usr_d  output  WIDTH  USR parallel data
- busy  output  1  command in progress
- done  output  1  one-cycle completion pulse

Behaviour:
- USR conventions:
  - Shift right: q <= {shift_r, q[WIDTH-1:1]}.
  - Shift left: q <= {q[WIDTH-2:0], shift_l}.
  - The USR samples usr_* on the same edge that advances this block.
- FSM states: IDLE, LOAD, SHIFT, DONE. All usr_* outputs are decoded from registered state, load/operand registers and remaining-count registers.
- IDLE:
  - cmd_ready=1, busy=0, usr_sel=00.
  - On cmd_valid&&cmd_ready: latch load, op, count, sin and data.
  - Next state is LOAD if cmd_load=1; else SHIFT if the op is a shift and count!=0; else DONE.
- LOAD (1 cycle): usr_sel=11, usr_d=latched data. Next state is SHIFT if the op is a shift and count!=0; else DONE.
- SHIFT:
  - usr_sel=latched op. The selected serial input carries sin; the other serial input is 0.
  - Remaining count decrements each cycle. The last cycle is remaining==1; then go to DONE.
- DONE (1 cycle): done=1, busy=1, usr_sel=00. Next state is IDLE.
- Command latency: accept edge to done-high cycle spans (load?1:0) + count + 1 cycles.
- Ops 00/11 with cmd_load=0: command goes IDLE→DONE and pulses done with no USR activity.
- count greater than WIDTH is legal; the bits simply shift out. count is not saturated.
- cmd_ready=0 in LOAD, SHIFT and DONE. A back-to-back command is accepted in the IDLE cycle after DONE, so the minimum spacing is 2 cycles for a null command.
- cmd_* inputs are don't-care when not accepted. Inputs change while busy without effect.
- usr_d holds the last latched data; it is 0 after reset.
- In all non-SHIFT states usr_shift_r=usr_shift_l=0.
- Reset:
  - While rst=1, cmd_ready, usr_sel, the serial inputs, busy and done are forced to 0 combinationally.
  - On the edge: state=IDLE, all latches and the count are cleared, usr_d=0.
  - Reset mid-command aborts with no done pulse.

Optional Feature:
- Macro: SHIFT_SEQ_ROTATE_EN.
- Defined: cmd_sin=1 on a shift command selects rotate mode. The serial input is taken combinationally from usr_q each SHIFT cycle: usr_q[0] for shift right, usr_q[WIDTH-1] for shift left. Serial-in 1 is therefore unavailable.
- Undefined: usr_q is unused and cmd_sin is the literal serial bit.

Decomposition:
- Package shift_seq_pkg holds:
  - State enum (IDLE, LOAD, SHIFT, DONE).
  - Mode localparams MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_LOAD=2'b11.
- Sub-module shift_seq_counter: loadable CNT_W down-counter with a last flag (remaining==1). Everything else lives in the top module.

Test Plan (WIDTH=4, USR instantiated, reset first):
- Load 1010, op=01, count=1, sin=1 → usr_sel 11 then 01; q=1101; done 3 cycles after accept.
- Load 0001, op=10, count=3, sin=0 → q=1000 after 3 shift cycles; busy high for 5 cycles.
- Null command (load=0, op=00) → done the cycle after accept, q unchanged, usr_sel stays 00; second command accepted 2 cycles after the first.
- Load 1111, op=01, count=6, sin=0 → q=0000; count>WIDTH completes normally.
- Reset asserted during SHIFT of count=5 → next cycle IDLE, no done, cmd_ready=1 after release.
- SHIFT_SEQ_ROTATE_EN defined: load 1000, op=01, count=4, sin=1 → q=1000 restored; intermediate values 0100, 0010, 0001.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared types and USR mode encodings for the shift sequencer.
// The rotate feature is enabled by defining SHIFT_SEQ_ROTATE_EN.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    SHIFT = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  function automatic logic is_shift_op(input logic [1:0] op);
    return (op == MODE_SHR) || (op == MODE_SHL);
  endfunction

endpackage

// File: rtl/shift_seq_counter.sv
// Loadable down-counter holding the remaining shift count; last flags remaining==1.
module shift_seq_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign last = (count == CNT_W'(1));

endmodule

// File: rtl/shift_sequencer.sv
// Command-driven sequencer for a universal shift register: optional load, N shifts, done pulse.
// Define SHIFT_SEQ_ROTATE_EN to make cmd_sin=1 select rotate (serial-in taken from usr_q).
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             cmd_sin,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] usr_q,
  output logic [1:0]       usr_sel,
  output logic             usr_shift_r,
  output logic             usr_shift_l,
  output logic [WIDTH-1:0] usr_d,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic [1:0]       op_r;
  logic             sin_r;
  logic [WIDTH-1:0] data_r;
  logic [CNT_W-1:0] remaining;
  logic             remaining_last;
  logic             accept;
  logic             serial_bit;

  assign cmd_ready = !rst && (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;

  shift_seq_counter #(.CNT_W(CNT_W)) u_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (cmd_count),
    .dec      (state == SHIFT),
    .count    (remaining),
    .last     (remaining_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op_r   <= MODE_HOLD;
      sin_r  <= 1'b0;
      data_r <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_r   <= cmd_op;
          sin_r  <= cmd_sin;
          data_r <= cmd_data;
          if (cmd_load)                                         state <= LOAD;
          else if (is_shift_op(cmd_op) && (cmd_count != '0))    state <= SHIFT;
          else                                                  state <= DONE;
        end
        LOAD:  state <= (is_shift_op(op_r) && (remaining != '0)) ? SHIFT : DONE;
        // remaining is never 0 here; the second term only guards against a stuck state
        SHIFT: if (remaining_last || (remaining == '0)) state <= DONE;
        DONE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SHIFT_SEQ_ROTATE_EN
  assign serial_bit = sin_r ? ((op_r == MODE_SHR) ? usr_q[0] : usr_q[WIDTH-1]) : 1'b0;
`else
  logic unused_usr_q;
  assign unused_usr_q = ^usr_q;
  assign serial_bit   = sin_r;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    usr_sel     = MODE_HOLD;
    usr_shift_r = 1'b0;
    usr_shift_l = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    if (!rst) begin
      case (state)
        LOAD: begin
          usr_sel = MODE_LOAD;
          busy    = 1'b1;
        end
        SHIFT: begin
          usr_sel     = op_r;
          busy        = 1'b1;
          usr_shift_r = (op_r == MODE_SHR) && serial_bit;
          usr_shift_l = (op_r == MODE_SHL) && serial_bit;
        end
        DONE: begin
          busy = 1'b1;
          done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign usr_d = data_r;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer driving a behavioural 4-bit USR.
// Honours SHIFT_SEQ_ROTATE_EN when defined.
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_load;
  logic [1:0] cmd_op;
  logic [2:0] cmd_count;
  logic       cmd_sin;
  logic [3:0] cmd_data;
  logic [3:0] q;
  logic [1:0] usr_sel;
  logic       usr_shift_r;
  logic       usr_shift_l;
  logic [3:0] usr_d;
  logic       busy;
  logic       done;

  int   errors = 0;
  int   checks = 0;
  logic [3:0] mq;
  time  acc_t;

  always #5 clk = ~clk;

  shift_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_load    (cmd_load),
    .cmd_op      (cmd_op),
    .cmd_count   (cmd_count),
    .cmd_sin     (cmd_sin),
    .cmd_data    (cmd_data),
    .usr_q       (q),
    .usr_sel     (usr_sel),
    .usr_shift_r (usr_shift_r),
    .usr_shift_l (usr_shift_l),
    .usr_d       (usr_d),
    .busy        (busy),
    .done        (done)
  );

  // Universal shift register under control of the sequencer
  always @(posedge clk) begin
    if (rst) q <= 4'h0;
    else case (usr_sel)
      2'b01: q <= {usr_shift_r, q[3:1]};
      2'b10: q <= {q[2:0], usr_shift_l};
      2'b11: q <= usr_d;
      default: ;
    endcase
  end

  // Issues one command from a negedge and checks every cycle up to the idle cycle after done.
  task automatic run_cmd(input logic ld, input logic [1:0] op, input logic [2:0] cnt,
                         input logic sin, input logic [3:0] data, input string name);
    int       w;
    int       k;
    logic     eb;
    logic [10:0] act;
    logic [10:0] exp;
    w = 0;
    while (!cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (!cmd_ready) begin
      errors++;
      $display("FAIL %s ready_timeout ready=%b required=1", name, cmd_ready);
      return;
    end
    cmd_valid = 1'b1;
    cmd_load  = ld;
    cmd_op    = op;
    cmd_count = cnt;
    cmd_sin   = sin;
    cmd_data  = data;
    @(posedge clk);
    acc_t = $time;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_load  = 1'($urandom);
    cmd_op    = 2'($urandom);
    cmd_count = 3'($urandom);
    cmd_sin   = 1'($urandom);
    cmd_data  = 4'($urandom);
    k = int'(ld) + (((op == 2'b01 || op == 2'b10) && cnt != 0) ? int'(cnt) : 0);
    for (int i = 0; i <= k; i++) begin
      act = {busy, done, cmd_ready, usr_sel, usr_shift_r, usr_shift_l, q};
      if (i == k) begin
        exp = {1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, mq};
      end else if (ld && i == 0) begin
        exp = {1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, mq};
        checks++;
        if (usr_d !== data) begin
          errors++;
          $display("FAIL %s load_data usr_d=%h required=%h", name, usr_d, data);
        end
        mq = data;
      end else begin
`ifdef SHIFT_SEQ_ROTATE_EN
        eb = sin ? ((op == 2'b01) ? mq[0] : mq[3]) : 1'b0;
`else
        eb = sin;
`endif
        exp = {1'b1, 1'b0, 1'b0, op, (op == 2'b01) & eb, (op == 2'b10) & eb, mq};
        if (op == 2'b01) mq = (mq >> 1) | (4'(eb) << 3);
        else             mq = 4'((mq << 1) | 4'(eb));
      end
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL %s cycle%0d {busy,done,ready,sel,sr,sl,q}=%b required=%b", name, i, act, exp);
      end
      @(negedge clk);
    end
    checks++;
    if ({busy, done, cmd_ready} !== 3'b001) begin
      errors++;
      $display("FAIL %s after_done {busy,done,ready}=%b required=001", name, {busy, done, cmd_ready});
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_load  = 1'b0;
    cmd_op    = 2'b00;
    cmd_count = 3'd0;
    cmd_sin   = 1'b0;
    cmd_data  = 4'h0;
    #1;
    checks++;
    if ({cmd_ready, usr_sel, usr_shift_r, usr_shift_l, busy, done} !== 7'b0) begin
      errors++;
      $display("FAIL reset_forced outs=%b required=0000000",
               {cmd_ready, usr_sel, usr_shift_r, usr_shift_l, busy, done});
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mq  = 4'h0;
    #1;
    checks++;
    if ({cmd_ready, busy, done, usr_sel, usr_d, q} !== {3'b100, 2'b00, 4'h0, 4'h0}) begin
      errors++;
      $display("FAIL reset_state {ready,busy,done,sel,usr_d,q}=%b required=1000000000000",
               {cmd_ready, busy, done, usr_sel, usr_d, q});
    end
  endtask

  task automatic test_directed();
    run_cmd(1'b1, 2'b01, 3'd1, 1'b1, 4'b1010, "load_shr1");
    run_cmd(1'b1, 2'b10, 3'd3, 1'b0, 4'b0001, "load_shl3");
    run_cmd(1'b1, 2'b01, 3'd6, 1'b0, 4'b1111, "count_gt_width");
    run_cmd(1'b0, 2'b10, 3'd7, 1'b1, 4'b0110, "shift_only_max");
    run_cmd(1'b1, 2'b01, 3'd0, 1'b1, 4'b0101, "load_count0");
    run_cmd(1'b1, 2'b11, 3'd5, 1'b0, 4'b1001, "load_op11");
  endtask

  task automatic test_back_to_back();
    time t1;
    run_cmd(1'b0, 2'b00, 3'd3, 1'b0, 4'hF, "null_op00");
    t1 = acc_t;
    run_cmd(1'b0, 2'b11, 3'd2, 1'b1, 4'hA, "null_op11");
    checks++;
    if (acc_t - t1 !== 20) begin
      errors++;
      $display("FAIL b2b_spacing delta=%0t required=20", acc_t - t1);
    end
  endtask

  task automatic test_reset_mid();
    logic saw_done;
    cmd_valid = 1'b1;
    cmd_load  = 1'b1;
    cmd_op    = 2'b01;
    cmd_count = 3'd5;
    cmd_sin   = 1'b0;
    cmd_data  = 4'b1111;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, usr_sel} !== 3'b101) begin
      errors++;
      $display("FAIL mid_in_shift {busy,sel}=%b required=101", {busy, usr_sel});
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({cmd_ready, usr_sel, usr_shift_r, usr_shift_l, busy, done} !== 7'b0) begin
      errors++;
      $display("FAIL mid_reset_forced outs=%b required=0000000",
               {cmd_ready, usr_sel, usr_shift_r, usr_shift_l, busy, done});
    end
    @(negedge clk);
    rst = 1'b0;
    mq  = 4'h0;
    #1;
    checks++;
    if ({cmd_ready, busy, done, usr_d} !== {3'b100, 4'h0}) begin
      errors++;
      $display("FAIL mid_after_release {ready,busy,done,usr_d}=%b required=1000000",
               {cmd_ready, busy, done, usr_d});
    end
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      saw_done = saw_done | done | busy;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_no_done activity=%b required=0", saw_done);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      run_cmd(1'($urandom), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
              1'($urandom), 4'($urandom_range(0, 15)), "random");
    end
  endtask

`ifdef SHIFT_SEQ_ROTATE_EN
  task automatic test_rotate();
    run_cmd(1'b1, 2'b01, 3'd4, 1'b1, 4'b1000, "rotate_right4");
    checks++;
    if (q !== 4'b1000) begin
      errors++;
      $display("FAIL rotate_restore q=%b required=1000", q);
    end
    run_cmd(1'b1, 2'b10, 3'd5, 1'b1, 4'b0011, "rotate_left5");
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef SHIFT_SEQ_ROTATE_EN
    test_rotate();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
